uart_tx_arbiter: RTL

- Round-robin arbiter that shares one UART transmitter (valid/ready byte stream, DATA_WIDTH wide) among NUM_REQ byte-stream requesters.
- A grant is held for a whole packet: it ends on req_last or after MAX_BURST beats, whichever comes first.
- Output is a single registered stage driving the transmitter's data/valid/ready interface.
- Sits between host-side producers (command responder, debug/log streams) and the UART TX serializer.

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream among NUM_REQ requesters.
// Handshake: a beat transfers on a rising edge where valid && ready; a source holds valid/data until then.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [IDW-1:0]                grant_id,
   output logic                          busy
);

   localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDW-1:0]          rr_ptr;
   logic [BCW-1:0]          beat_cnt;
   logic [IDW-1:0]          cand;
   logic [IDW-1:0]          pick_idx;
   logic                    pick_found;
   logic [DATA_WIDTH-1:0]   gnt_data;
   logic                    slot_free;
   logic                    accept;
   logic                    release_now;

   // First valid requester after the last one served, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IDW'(i)) gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // The output register can take a beat when empty or draining this cycle.
   assign slot_free   = !tx_valid || tx_ready;
   assign accept      = (state == GRANT) && req_valid[grant_id] && slot_free;
   assign release_now = req_last[grant_id] || (beat_cnt == BCW'(MAX_BURST - 1));
   assign busy        = (state == GRANT) || tx_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (pick_found) state_nxt = GRANT;
         end
         GRANT: begin
            req_ready[grant_id] = slot_free;
            if (accept && release_now) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
         rr_ptr   <= IDW'(NUM_REQ - 1);
      end else begin
         if (state == IDLE && pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
         end
         // A refill in the same cycle as a drain keeps tx_valid high.
         if (accept) begin
            tx_data  <= gnt_data;
            tx_valid <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (release_now) rr_ptr <= grant_id;
         end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

endmodule
